// File: rtl/top_pool1.sv
// top_pool1: first 2x2 / stride-2 max-pooling stage of the LeNet5 datapath.
// Holds one IFM_SIZE x IFM_SIZE channel of IEEE-754 singles written by conv1,
// then on start streams it in raster order through a shift FIFO long enough
// to expose a full 2x2 window and writes the window maxima to conv2.
//
// Ports:
//   clk, reset                    clock, async active-low reset
//   data_in_from_previous         pixel written into the channel buffer
//   ifm_address_write_previous    buffer write address (row*IFM_SIZE+col)
//   ifm_enable_write_previous     buffer write strobe (ignored while running)
//   ifm_address_read_previous     buffer read-back address
//   ifm_enable_read_previous      buffer read-back strobe
//   start_from_previous           pulse: channel loaded
//   end_from_next                 next layer ready for a new channel
//   data_out_for_previous         registered read-back data
//   end_to_previous               pulse: buffer free again
//   data_out_for_next             pooled result
//   ifm_address_write_next        pooled result address i*IFM_SIZE_NEXT+j
//   ifm_enable_write_next         pooled result write strobe
//   start_to_next                 pulse: pooled channel complete
//
// state | meaning
// IDLE  | buffer writable; waits for a pending start plus end_from_next
// RUN   | reading the buffer and emitting pooled results
// DONE  | one cycle; handshakes completion to both neighbours
module top_pool1 #(
    parameter int DATA_WIDTH  = 32,
    parameter int IFM_SIZE    = 28,
    parameter int IFM_DEPTH   = 3,
    parameter int KERNAL_SIZE = 2,
    localparam int IFM_SIZE_NEXT         = (IFM_SIZE - KERNAL_SIZE) / 2 + 1,
    localparam int IFM_ADDRESS_SIZE      = $clog2(IFM_SIZE * IFM_SIZE),
    localparam int IFM_ADDRESS_SIZE_NEXT = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_WIDTH-1:0]            data_in_from_previous,
    input  logic [IFM_ADDRESS_SIZE-1:0]      ifm_address_write_previous,
    input  logic                             ifm_enable_write_previous,
    input  logic [IFM_ADDRESS_SIZE-1:0]      ifm_address_read_previous,
    input  logic                             ifm_enable_read_previous,
    input  logic                             start_from_previous,
    input  logic                             end_from_next,
    output logic [DATA_WIDTH-1:0]            data_out_for_previous,
    output logic                             end_to_previous,
    output logic [DATA_WIDTH-1:0]            data_out_for_next,
    output logic [IFM_ADDRESS_SIZE_NEXT-1:0] ifm_address_write_next,
    output logic                             ifm_enable_write_next,
    output logic                             start_to_next
);
    localparam int FIFO_SIZE = (KERNAL_SIZE - 1) * IFM_SIZE + KERNAL_SIZE;
    localparam int IFM_PIX   = IFM_SIZE * IFM_SIZE;
    localparam int OUT_PIX   = IFM_SIZE_NEXT * IFM_SIZE_NEXT;
    localparam int RC_W      = $clog2(IFM_SIZE);
    localparam int OC_W      = IFM_ADDRESS_SIZE_NEXT + 1;

    localparam logic [RC_W-1:0]             COL_LAST = RC_W'(IFM_SIZE - 1);
    localparam logic [IFM_ADDRESS_SIZE-1:0] PIX_LAST = IFM_ADDRESS_SIZE'(IFM_PIX - 1);
    localparam logic [OC_W-1:0]             OUT_ALL  = OC_W'(OUT_PIX);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t state_q, state_d;
    logic   pending_q, pending_d;

    logic [DATA_WIDTH-1:0]       mem [IFM_PIX];
    logic [DATA_WIDTH-1:0]       ram_q;
    logic [IFM_ADDRESS_SIZE-1:0] rd_cnt_q;
    logic [RC_W-1:0]             rd_row_q, rd_col_q;
    logic                        rd_busy_q;
    logic                        ram_vld_q, ram_odd_q;
    logic [DATA_WIDTH-1:0]       fifo_q [FIFO_SIZE];
    logic                        fifo_vld_q, fifo_odd_q;
    logic [OC_W-1:0]             out_cnt_q;

    logic [DATA_WIDTH-1:0]            dout_prev_q, dout_next_q;
    logic [IFM_ADDRESS_SIZE_NEXT-1:0] addr_next_q;
    logic                             we_next_q;
    logic [DATA_WIDTH-1:0]            pool_max;

    // Sign-magnitude compare: no FP unit needed. +0 wins over -0 because the
    // differing-sign case always picks the non-negative operand.
    function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
        if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1])
            return a[DATA_WIDTH-1] ? b : a;
        else if (!a[DATA_WIDTH-1])
            return (a[DATA_WIDTH-2:0] >= b[DATA_WIDTH-2:0]) ? a : b;
        else
            return (a[DATA_WIDTH-2:0] <= b[DATA_WIDTH-2:0]) ? a : b;
    endfunction

    // Taps: newest pixel (r,c), (r,c-1), and the same two from the row above.
    assign pool_max = fmax(fmax(fifo_q[0], fifo_q[1]),
                           fmax(fifo_q[IFM_SIZE], fifo_q[IFM_SIZE+1]));

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_from_previous) pending_d = 1'b1;
                if (pending_q && end_from_next) begin
                    state_d   = S_RUN;
                    pending_d = 1'b0;
                end
            end
            S_RUN:   if (out_cnt_q == OUT_ALL) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Buffer storage; writes are also taken in DONE so the previous layer can
    // refill right after seeing end_to_previous.
    always_ff @(posedge clk) begin
        if (ifm_enable_write_previous && state_q != S_RUN)
            mem[ifm_address_write_previous] <= data_in_from_previous;
        ram_q <= mem[rd_cnt_q];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            pending_q   <= 1'b0;
            rd_cnt_q    <= '0;
            rd_row_q    <= '0;
            rd_col_q    <= '0;
            rd_busy_q   <= 1'b0;
            ram_vld_q   <= 1'b0;
            ram_odd_q   <= 1'b0;
            fifo_vld_q  <= 1'b0;
            fifo_odd_q  <= 1'b0;
            out_cnt_q   <= '0;
            dout_prev_q <= '0;
            dout_next_q <= '0;
            addr_next_q <= '0;
            we_next_q   <= 1'b0;
            for (int i = 0; i < FIFO_SIZE; i++) fifo_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;

            if (ifm_enable_read_previous)
                dout_prev_q <= mem[ifm_address_read_previous];

            if (state_q == S_IDLE && state_d == S_RUN) begin
                rd_cnt_q  <= '0;
                rd_row_q  <= '0;
                rd_col_q  <= '0;
                rd_busy_q <= 1'b1;
                out_cnt_q <= '0;
            end else if (rd_busy_q) begin
                rd_cnt_q <= rd_cnt_q + 1'b1;
                if (rd_col_q == COL_LAST) begin
                    rd_col_q <= '0;
                    rd_row_q <= rd_row_q + 1'b1;
                end else begin
                    rd_col_q <= rd_col_q + 1'b1;
                end
                if (rd_cnt_q == PIX_LAST) rd_busy_q <= 1'b0;
            end

            // Pixel tags follow the data through the RAM and FIFO stages.
            ram_vld_q  <= rd_busy_q;
            ram_odd_q  <= rd_row_q[0] & rd_col_q[0];
            fifo_vld_q <= ram_vld_q;
            fifo_odd_q <= ram_odd_q;
            if (ram_vld_q) begin
                fifo_q[0] <= ram_q;
                for (int i = 1; i < FIFO_SIZE; i++) fifo_q[i] <= fifo_q[i-1];
            end

            we_next_q <= fifo_vld_q & fifo_odd_q;
            if (fifo_vld_q && fifo_odd_q) begin
                dout_next_q <= pool_max;
                addr_next_q <= out_cnt_q[IFM_ADDRESS_SIZE_NEXT-1:0];
                out_cnt_q   <= out_cnt_q + 1'b1;
            end
        end
    end

    assign data_out_for_previous  = dout_prev_q;
    assign data_out_for_next      = dout_next_q;
    assign ifm_address_write_next = addr_next_q;
    assign ifm_enable_write_next  = we_next_q;
    assign start_to_next          = (state_q == S_DONE);
    assign end_to_previous        = (state_q == S_DONE);

endmodule

// File: tb/tb_top_pool1.sv
module tb_top_pool1;
    localparam int N   = 28;
    localparam int NN  = 14;
    localparam int PIX = N * N;
    localparam int OUT = NN * NN;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_in_from_previous;
    logic [9:0]  ifm_address_write_previous;
    logic        ifm_enable_write_previous;
    logic [9:0]  ifm_address_read_previous;
    logic        ifm_enable_read_previous;
    logic        start_from_previous;
    logic        end_from_next;
    logic [31:0] data_out_for_previous;
    logic        end_to_previous;
    logic [31:0] data_out_for_next;
    logic [7:0]  ifm_address_write_next;
    logic        ifm_enable_write_next;
    logic        start_to_next;

    top_pool1 dut (
        .clk(clk), .reset(reset),
        .data_in_from_previous(data_in_from_previous),
        .ifm_address_write_previous(ifm_address_write_previous),
        .ifm_enable_write_previous(ifm_enable_write_previous),
        .ifm_address_read_previous(ifm_address_read_previous),
        .ifm_enable_read_previous(ifm_enable_read_previous),
        .start_from_previous(start_from_previous),
        .end_from_next(end_from_next),
        .data_out_for_previous(data_out_for_previous),
        .end_to_previous(end_to_previous),
        .data_out_for_next(data_out_for_next),
        .ifm_address_write_next(ifm_address_write_next),
        .ifm_enable_write_next(ifm_enable_write_next),
        .start_to_next(start_to_next)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_stn    = 0;

    logic [31:0] img [PIX];
    logic [31:0] cap_data [$];
    logic [7:0]  cap_addr [$];
    int first_k, done_gap, timed_out, etp_ok;

    // ---------------- reference model ----------------
    function automatic real to_real(input logic [31:0] b);
        if (b[30:23] == 8'd0) return b[31] ? -0.0 : 0.0;
        return $bitstoreal({b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] pool_ref(input int o);
        int i, j;
        logic [31:0] t [4];
        logic [31:0] best;
        i = o / NN;
        j = o % NN;
        t[0] = img[(2*i)*N + 2*j];
        t[1] = img[(2*i)*N + 2*j + 1];
        t[2] = img[(2*i+1)*N + 2*j];
        t[3] = img[(2*i+1)*N + 2*j + 1];
        best = t[0];
        for (int k = 1; k < 4; k++)
            if (to_real(t[k]) > to_real(best) ||
                (to_real(t[k]) == to_real(best) && best[31] && !t[k][31]))
                best = t[k];
        return best;
    endfunction

    function automatic logic [31:0] int_to_float(input int p);
        int e;
        logic [31:0] m;
        if (p == 0) return 32'd0;
        e = $clog2(p + 1) - 1;
        m = (32'(p) << (23 - e)) & 32'h007F_FFFF;
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    function automatic logic [31:0] rand_float();
        logic [31:0] r;
        if ($urandom_range(0, 9) == 0) return {1'($urandom_range(0, 1)), 31'd0};
        r = $urandom;
        return {r[31], 8'($urandom_range(100, 150)), r[22:0]};
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic load_img();
        for (int p = 0; p < PIX; p++) begin
            ifm_enable_write_previous  = 1'b1;
            ifm_address_write_previous = 10'(p);
            data_in_from_previous      = img[p];
            @(posedge clk); #1;
        end
        ifm_enable_write_previous = 1'b0;
    endtask

    task automatic pulse_start();
        start_from_previous = 1'b1;
        @(posedge clk); #1;
        start_from_previous = 1'b0;
    endtask

    task automatic collect(input int budget);
        int k, last_k;
        k = 0; last_k = -1000;
        cap_data.delete(); cap_addr.delete();
        first_k = -1; done_gap = -1; timed_out = 0; etp_ok = 1;
        while (1) begin
            @(posedge clk); #1;
            k++;
            if (ifm_enable_write_next) begin
                cap_data.push_back(data_out_for_next);
                cap_addr.push_back(ifm_address_write_next);
                if (first_k < 0) first_k = k;
                last_k = k;
            end
            if (end_to_previous !== start_to_next) etp_ok = 0;
            if (start_to_next) begin
                done_gap = k - last_k;
                n_stn++;
                break;
            end
            if (k >= budget) begin
                timed_out = 1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        #3;
        n_checks++;
        if ({data_out_for_previous, end_to_previous, data_out_for_next, ifm_address_write_next,
             ifm_enable_write_next, start_to_next} !== '0)
            $display("FAIL reset_outputs got %h/%b/%h/%h/%b/%b want all zero", data_out_for_previous,
                     end_to_previous, data_out_for_next, ifm_address_write_next,
                     ifm_enable_write_next, start_to_next);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_readback();
        ifm_enable_write_previous  = 1'b1;
        ifm_address_write_previous = 10'd100;
        data_in_from_previous      = 32'h3F80_0000;
        @(posedge clk); #1;
        ifm_enable_write_previous = 1'b0;
        ifm_enable_read_previous  = 1'b1;
        ifm_address_read_previous = 10'd100;
        @(posedge clk); #1;
        ifm_enable_read_previous  = 1'b0;
        n_checks++;
        if (data_out_for_previous !== 32'h3F80_0000)
            $display("FAIL readback got %h want 3f800000", data_out_for_previous);
        else n_pass++;
        ifm_address_read_previous = 10'd5;
        @(posedge clk); #1;
        n_checks++;
        if (data_out_for_previous !== 32'h3F80_0000)
            $display("FAIL readback_hold got %h want 3f800000", data_out_for_previous);
        else n_pass++;
    endtask

    task automatic test_ramp();
        int bad;
        for (int p = 0; p < PIX; p++) img[p] = int_to_float(p);
        end_from_next = 1'b1;
        load_img();
        pulse_start();
        collect(2000);
        n_checks++;
        if (timed_out || cap_data.size() != OUT)
            $display("FAIL ramp_count got %0d writes (timeout=%0d) want %0d", cap_data.size(), timed_out, OUT);
        else n_pass++;
        n_checks++;
        if (cap_data.size() < OUT || cap_data[0] !== 32'h41E8_0000 || cap_data[1] !== 32'h41F8_0000
            || cap_data[195] !== 32'h4443_C000)
            $display("FAIL ramp_corners got %h %h %h want 41e80000 41f80000 4443c000",
                     cap_data.size() > 0 ? cap_data[0] : 32'hx, cap_data.size() > 1 ? cap_data[1] : 32'hx,
                     cap_data.size() > 195 ? cap_data[195] : 32'hx);
        else n_pass++;
        bad = 0;
        for (int o = 0; o < OUT; o++)
            if (o >= cap_data.size() || cap_data[o] !== pool_ref(o) || cap_addr[o] !== 8'(o)) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL ramp_data got %0d bad results want 0", bad);
        else n_pass++;
        n_checks++;
        if (done_gap !== 1 || etp_ok !== 1)
            $display("FAIL ramp_done_timing got gap %0d etp_ok %0d want gap 1 etp_ok 1", done_gap, etp_ok);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (start_to_next !== 1'b0 || end_to_previous !== 1'b0)
            $display("FAIL ramp_done_pulse got stn %b etp %b want 0 0", start_to_next, end_to_previous);
        else n_pass++;
    endtask

    task automatic test_sign();
        int bad;
        for (int p = 0; p < PIX; p++) img[p] = rand_float();
        img[0]  = 32'hBF80_0000; img[1]  = 32'hC040_0000; img[28] = 32'hBF00_0000; img[29] = 32'hC000_0000;
        img[2]  = 32'h8000_0000; img[3]  = 32'h0000_0000; img[30] = 32'hBF80_0000; img[31] = 32'hC000_0000;
        img[4]  = 32'hC0A0_0000; img[5]  = 32'h3E80_0000; img[32] = 32'hBF80_0000; img[33] = 32'hC000_0000;
        load_img();
        pulse_start();
        collect(2000);
        n_checks++;
        if (cap_data.size() < 3 || cap_data[0] !== 32'hBF00_0000)
            $display("FAIL sign_all_neg got %h want bf000000", cap_data.size() > 0 ? cap_data[0] : 32'hx);
        else n_pass++;
        n_checks++;
        if (cap_data.size() < 3 || cap_data[1] !== 32'h0000_0000)
            $display("FAIL sign_zero got %h want 00000000", cap_data.size() > 1 ? cap_data[1] : 32'hx);
        else n_pass++;
        n_checks++;
        if (cap_data.size() < 3 || cap_data[2] !== 32'h3E80_0000)
            $display("FAIL sign_mixed got %h want 3e800000", cap_data.size() > 2 ? cap_data[2] : 32'hx);
        else n_pass++;
        bad = 0;
        for (int o = 0; o < OUT; o++)
            if (o >= cap_data.size() || cap_data[o] !== pool_ref(o) || cap_addr[o] !== 8'(o)) bad++;
        n_checks++;
        if (bad != 0 || cap_data.size() != OUT)
            $display("FAIL sign_random_data got %0d bad of %0d writes want 0 of %0d", bad, cap_data.size(), OUT);
        else n_pass++;
    endtask

    task automatic test_gating();
        int early, bad;
        for (int p = 0; p < PIX; p++) img[p] = rand_float();
        end_from_next = 1'b0;
        load_img();
        pulse_start();
        early = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (ifm_enable_write_next || start_to_next) early++;
        end
        n_checks++;
        if (early != 0) $display("FAIL gating_hold got %0d active cycles want 0", early);
        else n_pass++;
        end_from_next = 1'b1;
        collect(2000);
        // end_from_next is seen at the first edge (k=1), which is RUN entry;
        // the first result lands 3+29 edges later.
        n_checks++;
        if (first_k !== 33) $display("FAIL gating_latency got %0d want 33", first_k);
        else n_pass++;
        bad = 0;
        for (int o = 0; o < OUT; o++)
            if (o >= cap_data.size() || cap_data[o] !== pool_ref(o) || cap_addr[o] !== 8'(o)) bad++;
        n_checks++;
        if (bad != 0 || cap_data.size() != OUT || timed_out)
            $display("FAIL gating_data got %0d bad of %0d writes want 0 of %0d", bad, cap_data.size(), OUT);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int bad, stn0;
        stn0 = n_stn;
        end_from_next = 1'b1;
        for (int ch = 0; ch < 6; ch++) begin
            for (int p = 0; p < PIX; p++) img[p] = rand_float();
            load_img();
            pulse_start();
            collect(2000);
            bad = 0;
            for (int o = 0; o < OUT; o++)
                if (o >= cap_data.size() || cap_data[o] !== pool_ref(o) || cap_addr[o] !== 8'(o)) bad++;
            n_checks++;
            if (bad != 0 || cap_data.size() != OUT || timed_out)
                $display("FAIL b2b_ch%0d_data got %0d bad of %0d writes want 0 of %0d", ch, bad, cap_data.size(), OUT);
            else n_pass++;
            n_checks++;
            if (done_gap !== 1 || etp_ok !== 1)
                $display("FAIL b2b_ch%0d_done got gap %0d etp_ok %0d want 1 1", ch, done_gap, etp_ok);
            else n_pass++;
        end
        n_checks++;
        if (n_stn - stn0 != 6) $display("FAIL b2b_pulses got %0d want 6", n_stn - stn0);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int bad;
        for (int p = 0; p < PIX; p++) img[p] = rand_float();
        end_from_next = 1'b1;
        load_img();
        pulse_start();
        repeat (100) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({data_out_for_previous, end_to_previous, data_out_for_next, ifm_address_write_next,
             ifm_enable_write_next, start_to_next} !== '0)
            $display("FAIL midrun_reset got %h/%b/%h/%h/%b/%b want all zero", data_out_for_previous,
                     end_to_previous, data_out_for_next, ifm_address_write_next,
                     ifm_enable_write_next, start_to_next);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        for (int p = 0; p < PIX; p++) img[p] = rand_float();
        load_img();
        pulse_start();
        collect(2000);
        bad = 0;
        for (int o = 0; o < OUT; o++)
            if (o >= cap_data.size() || cap_data[o] !== pool_ref(o) || cap_addr[o] !== 8'(o)) bad++;
        n_checks++;
        if (bad != 0 || cap_data.size() != OUT || timed_out || done_gap !== 1)
            $display("FAIL midrun_recover got %0d bad of %0d writes gap %0d want 0 of %0d gap 1",
                     bad, cap_data.size(), done_gap, OUT);
        else n_pass++;
    endtask

    initial begin
        data_in_from_previous      = '0;
        ifm_address_write_previous = '0;
        ifm_enable_write_previous  = 1'b0;
        ifm_address_read_previous  = '0;
        ifm_enable_read_previous   = 1'b0;
        start_from_previous        = 1'b0;
        end_from_next              = 1'b1;
        test_reset();
        test_readback();
        test_ramp();
        test_sign();
        test_gating();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/top_pool1.md
Name: top_pool1

Overview:
- First max-pooling layer of the LeNet5 datapath; sits between the conv1 stage (previous) and conv2 (next).
- Buffers one IFM_SIZE x IFM_SIZE channel of IEEE-754 single-precision values written by the previous layer.
- On start, streams the channel through a line-buffer FIFO and emits KERNAL_SIZE x KERNAL_SIZE, stride-2 max-pool results with write addresses for the next layer.
- Handshakes completion to both neighbours.

Parameters:
- DATA_WIDTH, 32, word width (IEEE-754 single).
- IFM_SIZE, 28, input feature-map side.
- IFM_DEPTH, 3, channels per frame; documentation only, no behaviour depends on it (each start processes exactly one channel).
- KERNAL_SIZE, 2, pooling window side; stride fixed at 2.
- Derived IFM_SIZE_NEXT = (IFM_SIZE-KERNAL_SIZE)/2+1 (14).
- Derived IFM_ADDRESS_SIZE = clog2(IFM_SIZE^2) (10).
- Derived IFM_ADDRESS_SIZE_NEXT = clog2(IFM_SIZE_NEXT^2) (8).
- Derived FIFO_SIZE = (KERNAL_SIZE-1)*IFM_SIZE+KERNAL_SIZE (30).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- data_in_from_previous  in  DATA_WIDTH  pixel written into the IFM buffer.
- ifm_address_write_previous  in  IFM_ADDRESS_SIZE  buffer write address (raster order: row*IFM_SIZE+col).
- ifm_enable_write_previous  in  1  buffer write strobe.
- ifm_address_read_previous  in  IFM_ADDRESS_SIZE  buffer read-back address.
- ifm_enable_read_previous  in  1  buffer read-back strobe.
- start_from_previous  in  1  one-cycle pulse: channel is loaded, begin pooling.
- end_from_next  in  1  next layer is ready to accept a new channel.
- data_out_for_previous  out  DATA_WIDTH  registered read-back data.
- end_to_previous  out  1  one-cycle pulse: channel consumed, buffer free.
- data_out_for_next  out  DATA_WIDTH  pooled result.
- ifm_address_write_next  out  IFM_ADDRESS_SIZE_NEXT  result address, i*IFM_SIZE_NEXT+j.
- ifm_enable_write_next  out  1  result valid / write strobe.
- start_to_next  out  1  one-cycle pulse: full pooled channel delivered.

Behaviour:
- Reset (reset=0, async): all outputs 0, FSM to IDLE, counters and FIFO cleared. Buffer RAM contents need not be cleared.
- Buffer writes:
  - Accepted on any edge with ifm_enable_write_previous=1 while in IDLE.
  - Ignored while busy.
- Read-back: data_out_for_previous <= RAM[ifm_address_read_previous] when ifm_enable_read_previous=1, 1-cycle latency; otherwise holds.
- FSM states:
  - IDLE: start_from_previous sets a pending flag. With pending set and end_from_next=1, go to RUN and clear pending. A start received while end_from_next=0 stays pending until end_from_next=1.
  - RUN: read address p=0..IFM_SIZE^2-1, one per cycle; 1-cycle RAM latency; each read word is shifted into a FIFO_SIZE-deep shift FIFO.
  - DONE: one cycle; pulse start_to_next and end_to_previous together; then return to IDLE.
  - start_from_previous in RUN or DONE is ignored.
- Pooling:
  - When pixel (r,c) with r and c both odd enters the FIFO, the window taps are FIFO[0], FIFO[1], FIFO[IFM_SIZE], FIFO[IFM_SIZE+1], i.e. (r,c), (r,c-1), (r-1,c), (r-1,c-1).
  - Their max is registered to data_out_for_next with ifm_enable_write_next=1 and address ((r-1)/2)*IFM_SIZE_NEXT+(c-1)/2.
  - Timing: read of p at cycle S+1+p (S = RUN entry); FIFO shift at S+2+p; output valid at S+3+p.
  - ifm_enable_write_next is high exactly IFM_SIZE_NEXT^2 (196) single cycles per channel, low otherwise.
  - data_out_for_next and the address hold their last values when not enabled.
- Float max (no FP unit, pure bit compare):
  - Signs differ: pick the non-negative value. +0 beats -0.
  - Both positive: larger magnitude bits.
  - Both negative: smaller magnitude bits.
  - Equal: either.
  - NaN is not special-cased.
- DONE entered the cycle after the last result (pixel 783) is written, so start_to_next follows the final ifm_enable_write_next by 1 cycle.
- Back-to-back channels: the previous layer may rewrite the buffer immediately after end_to_previous. The next start is processed identically; the output address restarts at 0.
- Reset mid-RUN aborts the channel; no start_to_next or end_to_previous is issued.

Test Plan:
- Ramp channel: write RAM[p]=float(p), start with end_from_next=1 -> 196 writes; address 0 gives 29.0, address 1 gives 31.0, address 195 gives 783.0; start_to_next and end_to_previous pulse once, 1 cycle after the last write.
- Sign handling: window {-1.0,-3.0,-0.5,-2.0} -> -0.5. Window {-0.0,+0.0,-1.0,-2.0} -> +0.0 (0x00000000). Window {-5.0,0.25,-1.0,-2.0} -> 0.25.
- Read-back: write 0x3F800000 at address 100, pulse read enable at 100 -> data_out_for_previous=0x3F800000 next cycle.
- Gating: start with end_from_next=0 -> no output writes; raise end_from_next 10 cycles later -> first write 3+29 cycles after RUN entry.
- Six consecutive channels with distinct data -> 6x196 correct results; each run's addresses restart at 0; six start_to_next pulses.
- Reset asserted mid-RUN -> all outputs 0 immediately; a subsequent start gives a complete, correct channel.
